// File: rtl/ika87ad_mc_pkg.sv
// ============================================================================
// ika87ad_mc_pkg
// Shared bus-cycle codes, cycle-length helper and reset entry address for
// the ika87ad microcode sequencer.
// Revision: 1.0
// ============================================================================
`default_nettype none

package ika87ad_mc_pkg;

  typedef enum logic [1:0] {
    RD4  = 2'b00,
    RD3  = 2'b01,
    WR3  = 2'b10,
    IDLE = 2'b11
  } buscyc_e;

  localparam logic [7:0] IRD_ADDR_DEFAULT = 8'hFE;
  localparam int         MCW_DEFAULT      = 18;

  // Only the opcode fetch runs four T-states; every other cycle runs three.
  function automatic logic [2:0] cycle_len(input buscyc_e code);
    return (code == RD4) ? 3'd4 : 3'd3;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ika87ad_microcode_sequencer_if.sv
// ============================================================================
// ika87ad_microcode_sequencer_if
// Timing, ROM and decoder signals between the sequencer and its neighbours.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface ika87ad_microcode_sequencer_if #(
  parameter int MCW = 18
);

  logic           i_CEN;
  logic           i_HOLD;
  logic [MCW-1:0] i_MC_WORD;
  logic           i_DEC_VALID;
  logic [7:0]     i_DEC_ADDR;

  logic [7:0]     o_MCROM_ADDR;
  logic           o_MCROM_READ_TICK;
  logic [1:0]     o_TSTATE;
  logic [1:0]     o_BUSCYC;
  logic           o_CYCLE_END;
  logic           o_OPCODE_FETCH;
  logic           o_DEC_STALL;

  // Sequencer side.
  modport master (
    input  i_CEN, i_HOLD, i_MC_WORD, i_DEC_VALID, i_DEC_ADDR,
    output o_MCROM_ADDR, o_MCROM_READ_TICK, o_TSTATE, o_BUSCYC,
           o_CYCLE_END, o_OPCODE_FETCH, o_DEC_STALL
  );

  // Environment side: timing, ROM and decoder.
  modport slave (
    output i_CEN, i_HOLD, i_MC_WORD, i_DEC_VALID, i_DEC_ADDR,
    input  o_MCROM_ADDR, o_MCROM_READ_TICK, o_TSTATE, o_BUSCYC,
           o_CYCLE_END, o_OPCODE_FETCH, o_DEC_STALL
  );

endinterface

`default_nettype wire

// File: rtl/ika87ad_tstate_counter.sv
// ============================================================================
// ika87ad_tstate_counter
// T-state counter with hold gating, decoder stall and cycle-end pulse.
// Revision: 1.0
// ============================================================================
`default_nettype none

module ika87ad_tstate_counter
  import ika87ad_mc_pkg::*;
(
  input  wire logic       i_CLK,
  input  wire logic       i_RST,
  input  wire logic       i_CEN,
  input  wire logic       i_HOLD,
  input  wire buscyc_e    i_CODE,
  input  wire logic       i_DEC_READY,
  output logic [1:0]      o_TSTATE,
  output logic            o_CYCLE_END,
  output logic            o_T0_ADV,
  output logic            o_DEC_STALL
);

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_STALL = 1'b1
  } state_e;

  state_e     state_q, state_d;
  logic [1:0] tstate_q, tstate_d;
  logic       cycle_end_w;
  logic       t0_adv_w;
  logic       adv_w;
  logic       last_w;
  logic [2:0] len_w;

  assign len_w  = cycle_len(i_CODE);
  assign adv_w  = i_CEN & ~i_HOLD;
  assign last_w = ({1'b0, tstate_q} == (len_w - 3'd1));

  always_comb begin
    state_d     = state_q;
    tstate_d    = tstate_q;
    cycle_end_w = 1'b0;
    t0_adv_w    = 1'b0;
    if (adv_w) begin
      if (last_w) begin
        // An opcode fetch may only finish once the decoder has an entry.
        if ((i_CODE != RD4) || i_DEC_READY) begin
          cycle_end_w = 1'b1;
          tstate_d    = 2'd0;
          state_d     = ST_RUN;
        end else begin
          state_d     = ST_STALL;
        end
      end else begin
        tstate_d = tstate_q + 2'd1;
        t0_adv_w = (tstate_q == 2'd0);
      end
    end
  end

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      state_q  <= ST_RUN;
      tstate_q <= 2'd0;
    end else begin
      state_q  <= state_d;
      tstate_q <= tstate_d;
    end
  end

  assign o_TSTATE    = tstate_q;
  assign o_CYCLE_END = cycle_end_w & ~i_RST;
  assign o_T0_ADV    = t0_adv_w & ~i_RST;
  assign o_DEC_STALL = (state_q == ST_STALL);

endmodule

`default_nettype wire

// File: rtl/ika87ad_microcode_sequencer.sv
// ============================================================================
// ika87ad_microcode_sequencer
// Micro-address sequencer feeding the microcode ROM: next-address mux,
// decoder entry latch, bus-cycle code register and ROM read tick.
// Revision: 1.0
// ============================================================================
`default_nettype none

module ika87ad_microcode_sequencer
  import ika87ad_mc_pkg::*;
#(
  parameter logic [7:0] IRD_ADDR = IRD_ADDR_DEFAULT,
  parameter int         MCW      = MCW_DEFAULT
) (
  input  wire logic                        i_CLK,
  input  wire logic                        i_RST,
  ika87ad_microcode_sequencer_if.master    bus
);

  logic [7:0] addr_q, addr_d;
  buscyc_e    buscyc_q;
  logic       lat_valid_q;
  logic [7:0] lat_addr_q;
  logic       upd_q;
  logic       boot_q;
  logic       tick_q;

  logic [1:0] tstate_w;
  logic       cycle_end_w;
  logic       t0_adv_w;
  logic       dec_stall_w;
  logic       dec_ready_w;
  logic       consume_w;

  assign dec_ready_w = lat_valid_q | bus.i_DEC_VALID;
  assign consume_w   = cycle_end_w & (buscyc_q == RD4);

  ika87ad_tstate_counter u_tstate (
    .i_CLK       (i_CLK),
    .i_RST       (i_RST),
    .i_CEN       (bus.i_CEN),
    .i_HOLD      (bus.i_HOLD),
    .i_CODE      (buscyc_q),
    .i_DEC_READY (dec_ready_w),
    .o_TSTATE    (tstate_w),
    .o_CYCLE_END (cycle_end_w),
    .o_T0_ADV    (t0_adv_w),
    .o_DEC_STALL (dec_stall_w)
  );

  always_comb begin
    addr_d = addr_q;
    if (cycle_end_w) begin
      if (buscyc_q == RD4) begin
        // A same-clock decoder pulse bypasses the latch.
        addr_d = bus.i_DEC_VALID ? bus.i_DEC_ADDR : lat_addr_q;
      end else begin
        addr_d = addr_q + 8'd1;
      end
    end
  end

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      addr_q      <= IRD_ADDR;
      buscyc_q    <= RD4;
      lat_valid_q <= 1'b0;
      lat_addr_q  <= 8'h00;
    end else begin
      addr_q <= addr_d;
      if (t0_adv_w) begin
        buscyc_q <= buscyc_e'(bus.i_MC_WORD[1:0]);
      end
      if (consume_w) begin
        lat_valid_q <= 1'b0;
      end else if (bus.i_DEC_VALID) begin
        lat_valid_q <= 1'b1;
        lat_addr_q  <= bus.i_DEC_ADDR;
      end
    end
  end

  // Read tick trails every address load by one clock; reset counts as a load.
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      upd_q  <= 1'b0;
      boot_q <= 1'b1;
      tick_q <= 1'b0;
    end else begin
      upd_q  <= cycle_end_w;
      boot_q <= 1'b0;
      tick_q <= upd_q | boot_q;
    end
  end

  generate
    if (MCW > 2) begin : g_spare_bits
      logic w_unused_spare;
      assign w_unused_spare = ^bus.i_MC_WORD[MCW-1:2];
    end
  endgenerate

  assign bus.o_MCROM_ADDR      = addr_q;
  assign bus.o_MCROM_READ_TICK = tick_q;
  assign bus.o_TSTATE          = tstate_w;
  assign bus.o_BUSCYC          = buscyc_q;
  assign bus.o_CYCLE_END       = cycle_end_w;
  assign bus.o_OPCODE_FETCH    = (buscyc_q == RD4);
  assign bus.o_DEC_STALL       = dec_stall_w;

endmodule

`default_nettype wire

// File: doc/ika87ad_microcode_sequencer.md
Name: ika87ad_microcode_sequencer

Overview:
Micro-program sequencer directly upstream of the microcode ROM. It counts T-states within each machine cycle and generates the ROM address and one-clock read tick. It decides the next micro-address: sequential step, or the decoder entry point after an opcode-fetch cycle. The registered ROM word feeds back only its bus-cycle code, which sets cycle length and opcode-fetch marking.

Parameters:
IRD_ADDR, 8'hFE, micro-address loaded on reset; its word is an RD4 cycle (first opcode fetch).
MCW, 18, width of the ROM word bus; only bits [1:0] are consumed.

Ports:
i_CLK  in  1  system clock
i_RST  in  1  synchronous reset, active-high
i_CEN  in  1  T-state tick; two i_CEN pulses never occur on adjacent clocks (minimum spacing 2 clocks)
i_HOLD  in  1  bus wait; freezes the T counter
i_MC_WORD  in  MCW  ROM output; [1:0] = bus-cycle code
i_DEC_VALID  in  1  decoder entry address valid (pulse)
i_DEC_ADDR  in  8  micro-address entry of the decoded opcode
o_MCROM_ADDR  out  8  registered ROM address
o_MCROM_READ_TICK  out  1  ROM read strobe, one clock
o_TSTATE  out  2  current T-state, 0-based
o_BUSCYC  out  2  bus-cycle code of the current cycle
o_CYCLE_END  out  1  one-clock pulse on the final T-state tick
o_OPCODE_FETCH  out  1  high while o_BUSCYC==RD4
o_DEC_STALL  out  1  stalled at the end of a fetch awaiting the decoder

Behaviour:
- Codes: RD4=2'b00 (4 T-states, opcode fetch); RD3=2'b01, WR3=2'b10, IDLE=2'b11 (3 T-states each).
- Reset (overrides everything):
  - o_MCROM_ADDR=IRD_ADDR; o_TSTATE=0; o_BUSCYC=RD4; o_MCROM_READ_TICK=1 on the first clock after reset release, 0 during reset.
  - o_CYCLE_END=0; o_DEC_STALL=0; decode latch cleared.
- T counting:
  - On i_CEN & !i_HOLD, o_TSTATE advances by one.
  - When o_TSTATE==len-1 on such a tick, o_CYCLE_END pulses for that clock and o_TSTATE returns to 0 (new cycle).
  - i_HOLD high: no advance and no cycle end; ticks are lost, not queued.
- Address update at cycle end (the same clock edge):
  - If o_BUSCYC==RD4: next address = latched decode address, and the latch is cleared.
  - Otherwise: next address = o_MCROM_ADDR+1, modulo 256 (8'hFF wraps to 8'h00, no flag).
- o_MCROM_READ_TICK pulses exactly one clock after each address update. The ROM data is therefore valid two clocks after the update.
- o_BUSCYC latches i_MC_WORD[1:0] on the first i_CEN of the new cycle (the T0→T1 advance). During T0, o_BUSCYC keeps the previous value. Length is re-evaluated from the new code.
- Decode latch:
  - i_DEC_VALID captures i_DEC_ADDR; a later pulse overwrites the stored address (latest wins).
  - A pulse on the same clock as consumption is taken directly and not stored twice.
- Decode stall:
  - Applies when an RD4 cycle reaches its final tick with the latch empty and no i_DEC_VALID on that clock.
  - T stays at 3, o_DEC_STALL=1, no cycle end.
  - The cycle completes on the first i_CEN after the latch fills.
- Reset mid-cycle abandons the cycle immediately; no partial o_CYCLE_END.

Decomposition:
- Shared package ika87ad_mc_pkg holds:
  - the bus-cycle code constants RD4/RD3/WR3/IDLE and a typedef for the 2-bit code;
  - the cycle-length function (code→3/4);
  - IRD_ADDR default.
- One natural sub-module: ika87ad_tstate_counter (T counter, length select, hold and stall gating, cycle-end pulse).
- Address mux and decode latch stay in the top.

Test Plan:
- Reset release, ROM model returns RD4 at 8'hFE, i_DEC_VALID with 8'h20 during T1 → tick at 8'hFE, 4 T-states, cycle end, o_MCROM_ADDR=8'h20, tick next clock.
- Entry 8'h20 returns RD3, 8'h21 returns RD4 → 3-T cycle at 8'h20, then 8'h21 with o_OPCODE_FETCH=1; o_MCROM_ADDR jumps to the next decode address afterwards.
- i_HOLD high for 5 i_CEN ticks at T=1 of a WR3 cycle → o_TSTATE stays 1, no o_CYCLE_END; resumes and finishes 3 counted T-states.
- RD4 cycle ends with no decode → o_DEC_STALL=1 and T=3 held; i_DEC_VALID with 8'h40 → completes on the next i_CEN, address 8'h40.
- Sequential walk from 8'hFF with an RD3 word → next address 8'h00.
- i_RST asserted at T=2 of an RD3 cycle → next clock o_MCROM_ADDR=IRD_ADDR, o_TSTATE=0, no o_CYCLE_END.
